draw_cmd_encoder: RTL

- Producer end of the draw-command FIFO: takes one high-level draw request and packs it into one or two 32-bit command words.
- Writes those words into the shared command FIFO, honouring its full flag.
- Sits between game/score logic (requesters) and the command FIFO whose reader dispatches words to the pixel, rectangle and char draw engines.

---
 rtl/draw_cmd_pkg.sv | 53 +++++
 rtl/draw_cmd_pack.sv | 79 +++++++
 rtl/draw_cmd_encoder.sv | 89 ++++++++
 3 files changed

// File: rtl/draw_cmd_pkg.sv
// Shared constants for the draw-command FIFO producer: field widths, opcodes and bit offsets.
package draw_cmd_pkg;

  localparam int unsigned CMD_WIDTH      = 32;
  localparam int unsigned H_LOGIC_WIDTH  = 5;
  localparam int unsigned V_LOGIC_WIDTH  = 5;
  localparam int unsigned H_PHY_WIDTH    = 10;
  localparam int unsigned V_PHY_WIDTH    = 9;
  localparam int unsigned COLOR_ID_WIDTH = 8;
  localparam int unsigned CNT_WIDTH      = 16;

  localparam logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = 5'd31;
  localparam logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = 5'd23;
  localparam logic [H_PHY_WIDTH-1:0]   H_PHY_MAX   = 10'd639;
  localparam logic [V_PHY_WIDTH-1:0]   V_PHY_MAX   = 9'd479;

  localparam logic [3:0] OP_PIXEL_SP = 4'h0;
  localparam logic [3:0] OP_RECT_SP  = 4'h1;
  localparam logic [3:0] OP_RECT_PX  = 4'h9;
  localparam logic [3:0] OP_CHAR     = 4'hA;

  localparam int unsigned OPC_LSB       = 28;
  localparam int unsigned SP_X0_LSB     = 23;
  localparam int unsigned SP_Y0_LSB     = 18;
  localparam int unsigned SP_X1_LSB     = 13;
  localparam int unsigned SP_Y1_LSB     = 8;
  localparam int unsigned PIX_COLOR_LSB = 10;
  localparam int unsigned PX_X_LSB      = 18;
  localparam int unsigned PX_Y_LSB      = 9;
  localparam int unsigned PX_DATA_LSB   = 1;
  localparam int unsigned CH_COLOR_LSB  = 20;
  localparam int unsigned CH_SIZE_LSB   = 16;

  typedef enum logic [1:0] {
    ReqPixelSp = 2'd0,
    ReqRectSp  = 2'd1,
    ReqRectPx  = 2'd2,
    ReqChar    = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmit0 = 2'd1,
    StEmit1 = 2'd2
  } enc_state_e;

  // Place a field value at its bit offset inside a command word.
  function automatic logic [CMD_WIDTH-1:0] fld(input logic [CMD_WIDTH-1:0] val,
                                               input int unsigned lsb);
    return val << lsb;
  endfunction

endpackage

// File: rtl/draw_cmd_pack.sv
// Combinational packing of one draw request into word0/word1.
// DRAW_CMD_ENCODER_CLIP_EN clamps coordinates instead of truncating them.
module draw_cmd_pack
  import draw_cmd_pkg::*;
(
  input  logic [1:0]                op,
  input  logic [H_PHY_WIDTH-1:0]    x0,
  input  logic [V_PHY_WIDTH-1:0]    y0,
  input  logic [H_PHY_WIDTH-1:0]    x1,
  input  logic [V_PHY_WIDTH-1:0]    y1,
  input  logic [COLOR_ID_WIDTH-1:0] color,
  input  logic [7:0]                code,
  input  logic [3:0]                size,
  output logic [CMD_WIDTH-1:0]      word0,
  output logic [CMD_WIDTH-1:0]      word1,
  output logic                      two_words
);

  logic [H_LOGIC_WIDTH-1:0] lx0, lx1;
  logic [V_LOGIC_WIDTH-1:0] ly0, ly1;
  logic [H_PHY_WIDTH-1:0]   px0, px1;
  logic [V_PHY_WIDTH-1:0]   py0, py1;

`ifdef DRAW_CMD_ENCODER_CLIP_EN
  // Logic-grid compares use the full input width so large values saturate, not wrap.
  assign lx0 = (x0 > H_PHY_WIDTH'(H_LOGIC_MAX)) ? H_LOGIC_MAX : x0[H_LOGIC_WIDTH-1:0];
  assign lx1 = (x1 > H_PHY_WIDTH'(H_LOGIC_MAX)) ? H_LOGIC_MAX : x1[H_LOGIC_WIDTH-1:0];
  assign ly0 = (y0 > V_PHY_WIDTH'(V_LOGIC_MAX)) ? V_LOGIC_MAX : y0[V_LOGIC_WIDTH-1:0];
  assign ly1 = (y1 > V_PHY_WIDTH'(V_LOGIC_MAX)) ? V_LOGIC_MAX : y1[V_LOGIC_WIDTH-1:0];
  assign px0 = (x0 > H_PHY_MAX) ? H_PHY_MAX : x0;
  assign px1 = (x1 > H_PHY_MAX) ? H_PHY_MAX : x1;
  assign py0 = (y0 > V_PHY_MAX) ? V_PHY_MAX : y0;
  assign py1 = (y1 > V_PHY_MAX) ? V_PHY_MAX : y1;
`else
  assign lx0 = x0[H_LOGIC_WIDTH-1:0];
  assign lx1 = x1[H_LOGIC_WIDTH-1:0];
  assign ly0 = y0[V_LOGIC_WIDTH-1:0];
  assign ly1 = y1[V_LOGIC_WIDTH-1:0];
  assign px0 = x0;
  assign px1 = x1;
  assign py0 = y0;
  assign py1 = y1;
`endif

  always_comb begin
    word0     = '0;
    word1     = '0;
    two_words = 1'b0;
    unique case (req_op_e'(op))
      ReqPixelSp: begin
        word0 = fld(CMD_WIDTH'(OP_PIXEL_SP), OPC_LSB) | fld(CMD_WIDTH'(lx0), SP_X0_LSB) |
                fld(CMD_WIDTH'(ly0), SP_Y0_LSB) | fld(CMD_WIDTH'(color), PIX_COLOR_LSB);
      end
      ReqRectSp: begin
        word0 = fld(CMD_WIDTH'(OP_RECT_SP), OPC_LSB) | fld(CMD_WIDTH'(lx0), SP_X0_LSB) |
                fld(CMD_WIDTH'(ly0), SP_Y0_LSB) | fld(CMD_WIDTH'(lx1), SP_X1_LSB) |
                fld(CMD_WIDTH'(ly1), SP_Y1_LSB) | CMD_WIDTH'(color);
      end
      ReqRectPx: begin
        two_words = 1'b1;
        word0 = fld(CMD_WIDTH'(OP_RECT_PX), OPC_LSB) | fld(CMD_WIDTH'(px0), PX_X_LSB) |
                fld(CMD_WIDTH'(py0), PX_Y_LSB) | fld(CMD_WIDTH'(color), PX_DATA_LSB);
        word1 = fld(CMD_WIDTH'(OP_RECT_PX), OPC_LSB) | fld(CMD_WIDTH'(px1), PX_X_LSB) |
                fld(CMD_WIDTH'(py1), PX_Y_LSB) | fld(CMD_WIDTH'(color), PX_DATA_LSB) |
                CMD_WIDTH'(1);
      end
      ReqChar: begin
        two_words = 1'b1;
        word0 = fld(CMD_WIDTH'(OP_CHAR), OPC_LSB) | fld(CMD_WIDTH'(color), CH_COLOR_LSB) |
                fld(CMD_WIDTH'(size), CH_SIZE_LSB);
        word1 = fld(CMD_WIDTH'(OP_CHAR), OPC_LSB) | fld(CMD_WIDTH'(px0), PX_X_LSB) |
                fld(CMD_WIDTH'(py0), PX_Y_LSB) | fld(CMD_WIDTH'(code), PX_DATA_LSB) |
                CMD_WIDTH'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/draw_cmd_encoder.sv
// Draw-command FIFO producer: accepts a request, emits one or two packed words under ff_full.
// Coordinate clamping is enabled with DRAW_CMD_ENCODER_CLIP_EN (see draw_cmd_pack).
module draw_cmd_encoder
  import draw_cmd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [1:0]                req_op,
  input  logic [H_PHY_WIDTH-1:0]    req_x0,
  input  logic [V_PHY_WIDTH-1:0]    req_y0,
  input  logic [H_PHY_WIDTH-1:0]    req_x1,
  input  logic [V_PHY_WIDTH-1:0]    req_y1,
  input  logic [COLOR_ID_WIDTH-1:0] req_color,
  input  logic [7:0]                req_code,
  input  logic [3:0]                req_size,
  input  logic                      ff_full,
  output logic                      ff_wren,
  output logic [CMD_WIDTH-1:0]      ff_wdat,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      wr_cnt
);

  enc_state_e           state_q;
  logic [CMD_WIDTH-1:0] word0_q, word1_q;
  logic                 two_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;

  logic [CMD_WIDTH-1:0] word0_d, word1_d;
  logic                 two_d;

  draw_cmd_pack u_pack (
    .op        (req_op),
    .x0        (req_x0),
    .y0        (req_y0),
    .x1        (req_x1),
    .y1        (req_y1),
    .color     (req_color),
    .code      (req_code),
    .size      (req_size),
    .word0     (word0_d),
    .word1     (word1_d),
    .two_words (two_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      word0_q  <= '0;
      word1_q  <= '0;
      two_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      if (ff_wren) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
      unique case (state_q)
        StIdle: begin
          if (req_vld) begin
            word0_q <= word0_d;
            word1_q <= word1_d;
            two_q   <= two_d;
            state_q <= StEmit0;
          end
        end
        StEmit0: if (!ff_full) state_q <= two_q ? StEmit1 : StIdle;
        StEmit1: if (!ff_full) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write data is zero when idle so several producers can OR-merge onto the FIFO.
  always_comb begin
    ff_wren = 1'b0;
    ff_wdat = '0;
    if (state_q == StEmit0 && !ff_full) begin
      ff_wren = 1'b1;
      ff_wdat = word0_q;
    end else if (state_q == StEmit1 && !ff_full) begin
      ff_wren = 1'b1;
      ff_wdat = word1_q;
    end
  end

  assign req_rdy = (state_q == StIdle);
  assign busy    = (state_q != StIdle);
  assign wr_cnt  = wr_cnt_q;

endmodule
